// File: rtl/iic_byte_engine_if.sv
// iic_byte_engine_if: TX/RX FIFO handshake plus open-drain SCL/SDA pin bundle.
interface iic_byte_engine_if;
  logic [9:0] cmd_q;
  logic       cmd_rd;
  logic       cmd_empty;
  logic [8:0] rsp_data;
  logic       rsp_wr;
  logic       scl_i, scl_o, scl_t;
  logic       sda_i, sda_o, sda_t;
  modport master (input cmd_q, cmd_empty, scl_i, sda_i,
                  output cmd_rd, rsp_data, rsp_wr, scl_o, scl_t, sda_o, sda_t);
  modport slave (output cmd_q, cmd_empty, scl_i, sda_i,
                 input cmd_rd, rsp_data, rsp_wr, scl_o, scl_t, sda_o, sda_t);
endinterface

// File: rtl/iic_byte_engine.sv
// iic_byte_engine: byte-level I2C master between TX command FIFO and RX response FIFO.
// Optional clock stretching is enabled by defining IIC_CLK_STRETCH_EN.
module iic_byte_engine #(
  parameter real CLK_FREQ = 100e6,
  parameter real T_SSU    = 0.6e-6,
  parameter real T_SH     = 0.6e-6,
  parameter real T_DSU    = 1.3e-6,
  parameter real T_SCLH   = 0.9e-6,
  parameter real T_DH     = 0.3e-6,
  parameter real T_PSU    = 0.6e-6,
  parameter real T_PH     = 0.7e-6
) (
  input  logic               csi_clk,
  input  logic               csi_reset_n,
  iic_byte_engine_if.master  bus,
  output logic               busy,
  output logic               bus_owned
);
  function automatic int cycles(real t);
    return (int'(t * CLK_FREQ) < 1) ? 1 : int'(t * CLK_FREQ);
  endfunction
  localparam int N_SSU  = cycles(T_SSU);
  localparam int N_SH   = cycles(T_SH);
  localparam int N_DSU  = cycles(T_DSU);
  localparam int N_SCLH = cycles(T_SCLH);
  localparam int N_DH   = cycles(T_DH);
  localparam int N_PSU  = cycles(T_PSU);
  localparam int N_PH   = cycles(T_PH);
  if (N_SSU > 1023 || N_SH > 1023 || N_DSU > 1023 || N_SCLH > 1023 ||
      N_DH > 1023 || N_PSU > 1023 || N_PH > 1023) begin : g_range_err
    $error("iic_byte_engine: phase cycle count exceeds 10-bit counter");
  end
  localparam logic [9:0] C_SSU  = 10'(N_SSU - 1);
  localparam logic [9:0] C_SH   = 10'(N_SH - 1);
  localparam logic [9:0] C_DSU  = 10'(N_DSU - 1);
  localparam logic [9:0] C_SCLH = 10'(N_SCLH - 1);
  localparam logic [9:0] C_DH   = 10'(N_DH - 1);
  localparam logic [9:0] C_PSU  = 10'(N_PSU - 1);
  localparam logic [9:0] C_PH   = 10'(N_PH - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, SSU, SH, DSU, SCLH, DH, HOLD, RS_LOW, PLOW, PSU, PH
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] arg_q, arg_d, sh_q, sh_d;
  logic [8:0] rsp_q, rsp_d;
  logic       rd_q, rd_d, own_q, own_d, scl_q, scl_d, sda_q, sda_d;
  logic       hold_cnt, done, lvl;

`ifdef IIC_CLK_STRETCH_EN
  assign hold_cnt = ~bus.scl_i && (state_q == SSU || state_q == SCLH || state_q == PSU);
`else
  logic unused_scl;
  assign unused_scl = bus.scl_i;
  assign hold_cnt = 1'b0;
`endif
  assign done = cnt_q == '0 && !hold_cnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = (hold_cnt || cnt_q == '0) ? cnt_q : cnt_q - 10'd1;
    bit_d   = bit_q;
    arg_d   = arg_q;
    rd_d    = rd_q;
    own_d   = own_q;
    sh_d    = sh_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE:   if (!bus.cmd_empty) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        arg_d = bus.cmd_q[7:0];
        rd_d  = bus.cmd_q[9:8] == 2'b10;
        bit_d = '0;
        cnt_d = C_DSU;
        if (!own_q) begin
          state_d = bus.cmd_q[9:8] == 2'b01 ? SSU : IDLE;
          cnt_d   = C_SSU;
        end else if (bus.cmd_q[9:8] == 2'b01) state_d = RS_LOW;
        else if (bus.cmd_q[9:8] == 2'b11) state_d = PLOW;
        else state_d = DSU;
      end
      SSU:    if (done) begin state_d = SH; cnt_d = C_SH; own_d = 1'b1; end
      SH:     if (done) begin state_d = DSU; cnt_d = C_DSU; end
      DSU:    if (done) begin state_d = SCLH; cnt_d = C_SCLH; end
      SCLH:   if (done) begin
        state_d = DH;
        cnt_d   = C_DH;
        sh_d    = {sh_q[6:0], bus.sda_i};
        if (bit_q == 4'd8) rsp_d = rd_q ? {arg_q[0], sh_q} : {bus.sda_i, arg_q};
      end
      DH:     if (done) begin
        state_d = bit_q == 4'd8 ? HOLD : DSU;
        bit_d   = bit_q + 4'd1;
        cnt_d   = C_DSU;
      end
      HOLD:   if (!bus.cmd_empty) state_d = FETCH;
      RS_LOW: if (done) begin state_d = SSU; cnt_d = C_SSU; end
      PLOW:   if (done) begin state_d = PSU; cnt_d = C_PSU; end
      PSU:    if (done) begin state_d = PH; cnt_d = C_PH; own_d = 1'b0; end
      PH:     if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin levels are registered from the next state so they never glitch.
  always_comb begin
    lvl   = bit_d[3] ? (rd_d ? arg_d[0] : 1'b1) : (rd_d | arg_d[~bit_d[2:0]]);
    scl_d = !(state_d inside {DSU, DH, HOLD, RS_LOW, PLOW} ||
              (state_d inside {FETCH, DECODE} && own_d));
    sda_d = state_d inside {SH, PLOW, PSU} ? 1'b0 :
            state_d inside {DSU, SCLH, DH} ? lvl : 1'b1;
  end

  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      arg_q   <= '0;
      sh_q    <= '0;
      rsp_q   <= '0;
      rd_q    <= 1'b0;
      own_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      arg_q   <= arg_d;
      sh_q    <= sh_d;
      rsp_q   <= rsp_d;
      rd_q    <= rd_d;
      own_q   <= own_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign bus.cmd_rd   = state_q == FETCH;
  assign bus.rsp_wr   = state_q == DH && bit_q == 4'd8 && cnt_q == '0;
  assign bus.rsp_data = rsp_q;
  assign bus.scl_o    = 1'b0;
  assign bus.sda_o    = 1'b0;
  assign bus.scl_t    = scl_q;
  assign bus.sda_t    = sda_q;
  assign busy         = state_q != IDLE;
  assign bus_owned    = own_q;
endmodule
